// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//   Parametrised register file for the single-cycle RISC-V core.
//   It has two combinational read ports and one synchronous write port.
//   A sequential bulk-clear engine zeroes every entry, one entry per cycle,
//   so a context can be reset without pulsing the global reset.
//
// Parameters
//   DATA_W    width of each entry in bits
//   ADDR_W    address width; DEPTH = 2**ADDR_W entries
//   ZERO_REG  1: entry 0 always reads 0 and ignores writes (x0); 0: ordinary
//
// Optional feature
//   REGFILE_BYPASS_EN  when defined, an effective write is forwarded to any
//                      read port addressing the same entry in the same cycle.
//                      When undefined, reads return the stored value and the
//                      new value appears the cycle after the write.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   src_reg1   read port 1 address
//   src_reg2   read port 2 address
//   data_out1  read port 1 data (combinational)
//   data_out2  read port 2 data (combinational)
//   write_en   write request
//   dst_reg    write address
//   data_in    write data
//   clr_req    start a bulk clear (only honoured while idle)
//   clr_busy   high while the clear engine is zeroing entries
//   clr_done   one-cycle pulse after the last entry has been cleared
//   wr_drop    one-cycle pulse: a write request was discarded during a clear
// ---------------------------------------------------------------------------
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] src_reg1,
  input  logic [ADDR_W-1:0] src_reg2,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] dst_reg,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              zero_dst;
  logic              eff_write;
  logic              clr_last;

  // Entry 0 is hard-wired to zero only when ZERO_REG is set, so writes
  // to it are suppressed in that case. Writes are also refused while the
  // clear engine owns the storage.
  assign zero_dst  = (ZERO_REG != 0) && (dst_reg == '0);
  assign eff_write = write_en && (state == IDLE) && !zero_dst;
  assign clr_last  = (state == CLEAR) && (clr_cnt == LAST_IDX);
  assign clr_busy  = (state == CLEAR);

  // State register for the clear engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a request is only seen while idle, and the engine
  // returns to idle on the edge that zeroes the last entry.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clr_req) next_state = CLEAR;
      CLEAR:   if (clr_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Clear index. It is reloaded to zero when a clear starts and when it
  // finishes, so it never wraps past the last entry on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (state == IDLE) begin
      if (clr_req) clr_cnt <= '0;
    end else if (clr_last) begin
      clr_cnt <= '0;
    end else begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Registered status pulses: done follows the final clear edge, and a
  // write that arrived during a clear is reported one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      clr_done <= clr_last;
      wr_drop  <= write_en && (state == CLEAR);
    end
  end

  // Storage. The clear engine zeroes one entry per edge; otherwise the
  // write port updates the addressed entry. Global reset zeroes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (eff_write) begin
      mem[dst_reg] <= data_in;
    end
  end

  // Read ports. Entry 0 is forced to zero when ZERO_REG is set. With
  // bypass enabled a same-cycle effective write is forwarded; eff_write
  // already excludes entry 0 under ZERO_REG and any cycle during a clear.
  always_comb begin
    data_out1 = mem[src_reg1];
    data_out2 = mem[src_reg2];
`ifdef REGFILE_BYPASS_EN
    if (eff_write && (src_reg1 == dst_reg)) data_out1 = data_in;
    if (eff_write && (src_reg2 == dst_reg)) data_out2 = data_in;
`endif
    if ((ZERO_REG != 0) && (src_reg1 == '0)) data_out1 = '0;
    if ((ZERO_REG != 0) && (src_reg2 == '0)) data_out2 = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//   Scoreboard bench for regfile_param. Two instances are exercised: the
//   default configuration (32 x 32-bit, x0 hard-wired) and a small one
//   (8 x 64-bit, entry 0 ordinary). Each cycle the stimulus task drives one
//   instance, asks the reference model what that instance must show this
//   cycle, and queues the expectation; a monitor on the falling edge pops
//   and compares.
// ---------------------------------------------------------------------------
module tb_regfile_param;

  logic clk;
  logic rst_n;

  // Instance A: default parameters
  logic [4:0]  a_src1, a_src2, a_dst;
  logic [31:0] a_out1, a_out2, a_din;
  logic        a_we, a_clr, a_busy, a_done, a_drop;

  // Instance B: DATA_W=64, ADDR_W=3, ZERO_REG=0
  logic [2:0]  b_src1, b_src2, b_dst;
  logic [63:0] b_out1, b_out2, b_din;
  logic        b_we, b_clr, b_busy, b_done, b_drop;

  regfile_param dut_a (
    .clk(clk), .rst_n(rst_n),
    .src_reg1(a_src1), .src_reg2(a_src2),
    .data_out1(a_out1), .data_out2(a_out2),
    .write_en(a_we), .dst_reg(a_dst), .data_in(a_din),
    .clr_req(a_clr), .clr_busy(a_busy), .clr_done(a_done), .wr_drop(a_drop)
  );

  regfile_param #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .src_reg1(b_src1), .src_reg2(b_src2),
    .data_out1(b_out1), .data_out2(b_out2),
    .write_en(b_we), .dst_reg(b_dst), .data_in(b_din),
    .clr_req(b_clr), .clr_busy(b_busy), .clr_done(b_done), .wr_drop(b_drop)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    int          dut;
    logic [63:0] d1;
    logic [63:0] d2;
    logic        busy;
    logic        done;
    logic        drop;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model. A clear is tracked as "cycles left" plus the index of
  // the entry the next clear cycle zeroes (entries are zeroed in order).
  logic [63:0] mm [2][32];
  int          clr_left [2];
  int          clr_idx  [2];
  bit          done_f   [2];
  bit          drop_f   [2];
  int          depth_of [2] = '{32, 8};
  bit          zr_of    [2] = '{1'b1, 1'b0};
  logic [63:0] dmask_of [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) mm[d][i] = '0;
      clr_left[d] = 0;
      clr_idx[d]  = 0;
      done_f[d]   = 1'b0;
      drop_f[d]   = 1'b0;
    end
  endfunction

  function automatic logic [63:0] model_read(int d, int s, bit eff, int dst,
                                             logic [63:0] din);
    if (zr_of[d] && s == 0) return '0;
    if (BYPASS && eff && s == dst) return din;
    return mm[d][s];
  endfunction

  // Advance one instance's model across a rising edge.
  function automatic void model_edge(int d, bit we, int dst, logic [63:0] din,
                                     bit clr);
    bit eff;
    eff = we && clr_left[d] == 0 && !(zr_of[d] && dst == 0);
    done_f[d] = (clr_left[d] == 1);
    drop_f[d] = we && clr_left[d] > 0;
    if (clr_left[d] > 0) begin
      mm[d][clr_idx[d]] = '0;
      clr_idx[d]++;
      clr_left[d]--;
    end else begin
      if (eff) mm[d][dst] = din;
      if (clr) begin
        clr_left[d] = depth_of[d];
        clr_idx[d]  = 0;
      end
    end
  endfunction

  // Drive one cycle of stimulus to instance d (the other sits idle), queue
  // the expected outputs for this cycle, then step the models across the
  // coming edge. While rst is set, everything is held in reset.
  task automatic applyStimulus(input int d, input bit rst, input bit we,
                               input int dst, input logic [63:0] din,
                               input int s1, input int s2, input bit clr,
                               input string name);
    exp_t e;
    bit   eff;
    int   m;
    @(posedge clk);
    #1;
    m   = depth_of[d] - 1;
    dst = dst & m;
    s1  = s1 & m;
    s2  = s2 & m;
    din = din & dmask_of[d];
    a_we = 1'b0; a_clr = 1'b0; b_we = 1'b0; b_clr = 1'b0;
    if (d == 0) begin
      a_we = we; a_dst = 5'(dst); a_din = din[31:0];
      a_src1 = 5'(s1); a_src2 = 5'(s2); a_clr = clr;
    end else begin
      b_we = we; b_dst = 3'(dst); b_din = din;
      b_src1 = 3'(s1); b_src2 = 3'(s2); b_clr = clr;
    end
    rst_n = !rst;
    if (rst) model_reset();
    eff    = !rst && we && clr_left[d] == 0 && !(zr_of[d] && dst == 0);
    e.dut  = d;
    e.d1   = model_read(d, s1, eff, dst, din);
    e.d2   = model_read(d, s2, eff, dst, din);
    e.busy = clr_left[d] > 0;
    e.done = done_f[d];
    e.drop = drop_f[d];
    e.name = name;
    sbq.push_back(e);
    if (!rst) begin
      model_edge(d, we, dst, din, clr);
      model_edge(1 - d, 1'b0, 0, '0, 1'b0);
    end
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.dut == 0) begin
      cmp(e.name, "data_out1", {32'h0, a_out1}, e.d1);
      cmp(e.name, "data_out2", {32'h0, a_out2}, e.d2);
      cmp(e.name, "clr_busy", {63'h0, a_busy}, {63'h0, e.busy});
      cmp(e.name, "clr_done", {63'h0, a_done}, {63'h0, e.done});
      cmp(e.name, "wr_drop",  {63'h0, a_drop}, {63'h0, e.drop});
    end else begin
      cmp(e.name, "data_out1", b_out1, e.d1);
      cmp(e.name, "data_out2", b_out2, e.d2);
      cmp(e.name, "clr_busy", {63'h0, b_busy}, {63'h0, e.busy});
      cmp(e.name, "clr_done", {63'h0, b_done}, {63'h0, e.done});
      cmp(e.name, "wr_drop",  {63'h0, b_drop}, {63'h0, e.drop});
    end
  endtask

  // Monitor: outputs are combinational or registered, so every queued
  // expectation is due by the falling edge of the cycle it was issued in.
  always @(negedge clk) begin
    while (sbq.size() > 0) checkOutput(sbq.pop_front());
  end

  // Convenience wrappers.
  task automatic idle(input int d, input int s1, input int s2, input string n);
    applyStimulus(d, 1'b0, 1'b0, 0, '0, s1, s2, 1'b0, n);
  endtask

  task automatic read_all(input int d, input string n);
    for (int i = 0; i < depth_of[d]; i += 2) idle(d, i, i + 1, n);
  endtask

  task automatic rand_cycles(input int d, input int n, input string name);
    for (int i = 0; i < n; i++)
      applyStimulus(d, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                    {$urandom, $urandom}, int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), ($urandom_range(0, 39) == 0), name);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_we = 0; a_dst = 0; a_din = 0; a_src1 = 0; a_src2 = 0; a_clr = 0;
    b_we = 0; b_dst = 0; b_din = 0; b_src1 = 0; b_src2 = 0; b_clr = 0;
    model_reset();

    // Power-on reset
    applyStimulus(0, 1'b1, 1'b0, 0, '0, 3, 4, 1'b0, "por");
    applyStimulus(0, 1'b1, 1'b0, 0, '0, 5, 6, 1'b0, "por");
    idle(0, 1, 2, "por_release");

    // Basic write/read and the hard-wired x0
    applyStimulus(0, 1'b0, 1'b1, 5, 64'hDEADBEEF, 5, 0, 1'b0, "wr_x5");
    idle(0, 5, 0, "rd_x5");
    applyStimulus(0, 1'b0, 1'b1, 0, 64'h1, 0, 0, 1'b0, "wr_x0");
    idle(0, 5, 0, "rd_x0");

    // Same-cycle write and read of x7 (bypass dependent), then next cycle
    applyStimulus(0, 1'b0, 1'b1, 7, 64'h12345678, 7, 7, 1'b0, "bypass_x7");
    idle(0, 7, 5, "rd_x7");

    // Randomised traffic, including occasional clears
    rand_cycles(0, 300, "rand_a");
    for (int i = 0; i < 40; i++) idle(0, i, i + 1, "drain_a");

    // Fill every entry, clear with writes arriving mid-clear, read back
    for (int i = 0; i < 32; i++)
      applyStimulus(0, 1'b0, 1'b1, i, {$urandom, $urandom}, i, 31 - i, 1'b0, "fill");
    applyStimulus(0, 1'b0, 1'b1, 9, 64'hA5A5A5A5, 9, 3, 1'b1, "clr_start");
    for (int i = 0; i < 34; i++)
      applyStimulus(0, 1'b0, (i % 5 == 2), i, 64'hCAFE0000 + 64'(i), i, 31 - i,
                    (i == 4), "clearing");
    read_all(0, "after_clear");

    // Reset in the middle of a clear
    for (int i = 1; i < 32; i++)
      applyStimulus(0, 1'b0, 1'b1, i, {$urandom, $urandom}, i, 0, 1'b0, "refill");
    applyStimulus(0, 1'b0, 1'b0, 0, '0, 1, 2, 1'b1, "clr_start2");
    for (int i = 0; i < 10; i++) idle(0, 30, 31, "clear_run");
    applyStimulus(0, 1'b1, 1'b0, 0, '0, 30, 31, 1'b0, "rst_mid_clear");
    for (int i = 0; i < 4; i++) idle(0, 20 + i, 24 + i, "post_rst");
    read_all(0, "post_rst_read");

    // Second configuration: 64-bit data, 8 entries, entry 0 ordinary
    applyStimulus(1, 1'b0, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1'b0, "b_wr0");
    idle(1, 0, 1, "b_rd0");
    for (int i = 1; i < 8; i++)
      applyStimulus(1, 1'b0, 1'b1, i, {$urandom, $urandom}, i, 0, 1'b0, "b_fill");
    // clr_req held high across clr_done restarts the engine from idle
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 1'b0, (i == 3), 2, 64'h55, 0, 7, 1'b1, "b_clr_held");
    for (int i = 0; i < 12; i++) idle(1, i, 7 - i, "b_drain");
    rand_cycles(1, 150, "rand_b");
    for (int i = 0; i < 12; i++) idle(1, i, i + 3, "b_drain2");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
